// File: rtl/imem_dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter_pkg
//   Shared types for the instruction/data memory arbiter:
//     word_t        - 32-bit machine word
//     mem_owner_e   - which requester owns an in-flight read response
//     mem_req_t     - bundled request (req / we / addr / wdata)
//   plus default parameter values and a small helper that maps the winning
//   grant to the owner tag recorded for the response cycle.
// ---------------------------------------------------------------------------
package imem_dmem_arbiter_pkg;

    typedef logic [31:0] word_t;

    localparam int ADDR_WIDTH_DEFAULT   = 9;
    localparam int MAX_D_STREAK_DEFAULT = 4;

    // The starvation counter is 4 bits wide, which bounds MAX_D_STREAK to 1..15.
    localparam int STREAK_WIDTH = 4;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } mem_owner_e;

    typedef struct packed {
        logic  req;
        logic  we;
        word_t addr;
        word_t wdata;
    } mem_req_t;

    // Owner tag for a read granted this cycle: data wins the tag whenever
    // the data side holds the grant, otherwise the read belongs to fetch.
    function automatic mem_owner_e owner_of(input logic data_granted);
        return data_granted ? OWNER_DATA : OWNER_FETCH;
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_arb_streak_counter.sv
// ---------------------------------------------------------------------------
// arb_streak_counter
//   Starvation guard for the fetch requester. Counts consecutive data grants
//   issued while fetch is waiting and raises fetch_prio once the count has
//   reached MAX_D_STREAK, which forces the next contended cycle to fetch.
//
//   Ports:
//     clk        in   core clock
//     rst_n      in   asynchronous active-low reset (clears the streak)
//     i_req      in   fetch request pending
//     i_gnt      in   fetch granted this cycle
//     d_gnt      in   data granted this cycle
//     fetch_prio out  fetch must win the next contended cycle
// ---------------------------------------------------------------------------
module arb_streak_counter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic fetch_prio
);

    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_D_STREAK);
    localparam logic [STREAK_WIDTH-1:0] STREAK_ONE = STREAK_WIDTH'(1);

    logic [STREAK_WIDTH-1:0] streak_q;
    logic [STREAK_WIDTH-1:0] streak_next;

    // The streak only means something while fetch is actually waiting:
    // any fetch grant, or fetch dropping its request, starts it over.
    always_comb begin
        streak_next = streak_q;
        if (i_gnt || !i_req) begin
            streak_next = '0;
        end else if (d_gnt && (streak_q < STREAK_MAX)) begin
            streak_next = streak_q + STREAK_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_next;
        end
    end

    // Decided purely from registered state, so the grant logic that
    // consumes it has no combinational path back into the counter.
    assign fetch_prio = (streak_q >= STREAK_MAX);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
//   Shares one single-port, synchronous-read unified memory between the
//   fetch stage (read-only) and the memory stage (load/store). One access is
//   granted per cycle; data has priority, bounded by a starvation guard that
//   hands fetch the port after MAX_D_STREAK consecutive contended data
//   grants. Read data returns one cycle after the grant and is steered to
//   the requester that owned the read.
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     i_req/i_addr/i_flush       fetch request, byte address, redirect flush
//     i_gnt/i_rvalid/i_rdata     fetch grant, response valid, response data
//     d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//     d_gnt/d_rvalid/d_rdata     data grant, load valid, load data
//     StallF/StallM              requester waiting and not granted (comb.)
//     mem_en/mem_we/mem_addr     memory strobe, write enable, word address
//     mem_wdata/mem_rdata        memory write data, read data (1-cycle lat.)
// ---------------------------------------------------------------------------
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    input  logic                  i_flush,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,

    output logic                  StallF,
    output logic                  StallM,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    // -----------------------------------------------------------------------
    // Request bundling
    // -----------------------------------------------------------------------
    mem_req_t fetch_req;
    mem_req_t data_req;
    mem_req_t sel_req;

    assign fetch_req = '{req: i_req, we: 1'b0, addr: i_addr, wdata: '0};
    assign data_req  = '{req: d_req, we: d_we, addr: d_addr, wdata: d_wdata};

    // -----------------------------------------------------------------------
    // Grant decision
    // -----------------------------------------------------------------------
    logic fetch_prio;

    arb_streak_counter #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_gnt      (i_gnt),
        .d_gnt      (d_gnt),
        .fetch_prio (fetch_prio)
    );

    // Grants are forced low while reset is asserted so that every output
    // reads 0 during reset, even with requests already raised.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (d_req && !(i_req && fetch_prio)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    assign StallF = rst_n & i_req & ~i_gnt;
    assign StallM = rst_n & d_req & ~d_gnt;

    // -----------------------------------------------------------------------
    // Memory port
    // -----------------------------------------------------------------------
    assign sel_req   = d_gnt ? data_req : fetch_req;

    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & sel_req.we;
    // Byte offset and bits above the memory range are dropped: aliasing
    // across the 32-bit space is intentional and never flagged.
    assign mem_addr  = mem_en ? sel_req.addr[ADDR_WIDTH+1:2] : '0;
    assign mem_wdata = d_gnt ? sel_req.wdata : '0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_req.req, sel_req.addr[31:ADDR_WIDTH+2], sel_req.addr[1:0]};

    // -----------------------------------------------------------------------
    // Response tracking
    // -----------------------------------------------------------------------
    logic       read_gnt;
    logic       resp_pending_q;
    mem_owner_e resp_owner_q;
    logic       cancel_q;

    // Stores complete at grant time, so only reads leave a response behind.
    assign read_gnt = i_gnt | (d_gnt & ~d_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_pending_q <= 1'b0;
            resp_owner_q   <= OWNER_FETCH;
            cancel_q       <= 1'b0;
        end else begin
            resp_pending_q <= read_gnt;
            resp_owner_q   <= owner_of(d_gnt);
            // A fetch granted in the same cycle as a redirect is stale.
            cancel_q       <= i_flush & i_gnt;
        end
    end

    logic fetch_resp;
    logic data_resp;

    assign fetch_resp = resp_pending_q && (resp_owner_q == OWNER_FETCH);
    assign data_resp  = resp_pending_q && (resp_owner_q == OWNER_DATA);

    // A flush arriving in the response cycle also kills the fetch response;
    // data responses are never cancelled.
    assign i_rvalid = fetch_resp & ~cancel_q & ~i_flush;
    assign d_rvalid = data_resp;

    // Read data is steered bitwise: the owner sees mem_rdata, the other
    // requester sees zero.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rdata_route
            assign i_rdata[gi] = mem_rdata[gi] & fetch_resp;
            assign d_rdata[gi] = mem_rdata[gi] & data_resp;
        end
    endgenerate

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_dmem_arbiter
//   Directed scenarios followed by constrained-random traffic. A behavioural
//   model (array memory + pending-response record + wait counter) predicts
//   every DUT output each cycle; a few literal values pin the model itself.
// ---------------------------------------------------------------------------
module tb_imem_dmem_arbiter;

    localparam int AW    = 9;
    localparam int MAXS  = 4;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_flush, i_gnt, i_rvalid;
    logic [31:0]   i_addr, i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic          StallF, StallM, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .ADDR_WIDTH   (AW),
        .MAX_D_STREAK (MAXS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .StallF    (StallF),
        .StallM    (StallM),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_val(input int idx);
        return 32'h1000_0000 + 32'(idx * 3);
    endfunction

    // Physical memory attached to the DUT port (synchronous read).
    logic [31:0] phys [DEPTH];
    bit          phys_loaded = 1'b0;

    always @(posedge clk) begin
        if (!phys_loaded) begin
            for (int k = 0; k < DEPTH; k++) phys[k] <= init_val(k);
            phys_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) phys[mem_addr] <= mem_wdata;
            else        mem_rdata      <= phys[mem_addr];
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    int tests_run    = 0;
    int tests_failed = 0;
    bit verbose      = 1'b0;

    logic [31:0] ref_mem [DEPTH];
    bit          m_pend;
    bit          m_owner_data;
    bit          m_cancel;
    logic [31:0] m_data;
    int          m_waits;   // data grants in a row while fetch kept waiting

    logic        obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid, obs_mem_we;
    logic [31:0] obs_i_rdata, obs_d_rdata, obs_mem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend       = 1'b0;
        m_owner_data = 1'b0;
        m_cancel     = 1'b0;
        m_data       = '0;
        m_waits      = 0;
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = '0;
        i_flush = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    // One clock cycle: compare all outputs against the model at the falling
    // edge, advance the model, then return just after the rising edge so the
    // caller can drive the next cycle's inputs.
    task automatic step();
        bit ei, ed;
        int a_i, a_d;
        @(negedge clk);
        ed  = d_req && (!i_req || m_waits < MAXS);
        ei  = i_req && !ed;
        a_i = int'((i_addr >> 2) % DEPTH);
        a_d = int'((d_addr >> 2) % DEPTH);

        check("i_gnt",     32'(i_gnt),     32'(ei));
        check("d_gnt",     32'(d_gnt),     32'(ed));
        check("StallF",    32'(StallF),    32'(i_req && !ei));
        check("StallM",    32'(StallM),    32'(d_req && !ed));
        check("mem_en",    32'(mem_en),    32'(ei || ed));
        check("mem_we",    32'(mem_we),    32'(ed && d_we));
        check("mem_wdata", mem_wdata,      ed ? d_wdata : 32'h0);
        if (ei || ed) check("mem_addr", 32'(mem_addr), 32'(ed ? a_d : a_i));
        check("i_rvalid",  32'(i_rvalid),  32'(m_pend && !m_owner_data && !m_cancel && !i_flush));
        check("d_rvalid",  32'(d_rvalid),  32'(m_pend && m_owner_data));
        check("i_rdata",   i_rdata,        (m_pend && !m_owner_data) ? m_data : 32'h0);
        check("d_rdata",   d_rdata,        (m_pend && m_owner_data) ? m_data : 32'h0);

        obs_i_gnt    = i_gnt;
        obs_d_gnt    = d_gnt;
        obs_i_rvalid = i_rvalid;
        obs_d_rvalid = d_rvalid;
        obs_mem_we   = mem_we;
        obs_i_rdata  = i_rdata;
        obs_d_rdata  = d_rdata;
        obs_mem_addr = 32'(mem_addr);

        if (verbose && (ei || ed))
            $display("[TB] t=%0t grant=%s addr=%h we=%0d", $time, ed ? "D" : "I",
                     ed ? d_addr : i_addr, (ed && d_we));

        if (ed && d_we) ref_mem[a_d] = d_wdata;
        m_pend       = ei || (ed && !d_we);
        m_owner_data = ed;
        m_data       = ei ? ref_mem[a_i] : ref_mem[a_d];
        m_cancel     = i_flush && ei;
        if (ei || !i_req)               m_waits = 0;
        else if (ed && m_waits < MAXS)  m_waits = m_waits + 1;

        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(3) == 0) return $urandom;
        return 32'($urandom_range(63) * 4);
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] pat10;
        logic [4:0] pat5;
        rst_n = 1'b0;
        idle_inputs();
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_val(k);
        model_reset();
        obs_i_gnt = 1'b0;
        obs_d_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state: every output 0 even with both requests raised.
        i_req = 1'b1; d_req = 1'b1; d_wdata = 32'h1234_5678; i_addr = 32'h10; d_addr = 32'h20;
        #1;
        check("rst_i_gnt",    32'(i_gnt),    32'h0);
        check("rst_d_gnt",    32'(d_gnt),    32'h0);
        check("rst_StallF",   32'(StallF),   32'h0);
        check("rst_StallM",   32'(StallM),   32'h0);
        check("rst_mem_en",   32'(mem_en),   32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata,    32'h0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        verbose = 1'b1;

        // Fetch-only stream 0x0, 0x4, 0x8.
        i_req = 1'b1; i_addr = 32'h0; step();
        check("stream_gnt0", 32'(obs_i_gnt), 32'h1);
        i_addr = 32'h4; step();
        check("stream_rdata0", obs_i_rdata, 32'h1000_0000);
        i_addr = 32'h8; step();
        check("stream_rdata1", obs_i_rdata, 32'h1000_0003);
        idle_inputs(); step();
        check("stream_rdata2", obs_i_rdata, 32'h1000_0006);

        // Out-of-range, misaligned data address aliases onto word 0.
        d_req = 1'b1; d_addr = 32'h803; step();
        check("alias_addr", obs_mem_addr, 32'h0);
        idle_inputs(); step();
        check("alias_rdata", obs_d_rdata, 32'h1000_0000);

        // Store then load at 0x40.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; step();
        check("store_we",   32'(obs_mem_we), 32'h1);
        check("store_addr", obs_mem_addr,    32'h10);
        d_we = 1'b0; d_wdata = '0; step();
        check("store_no_rvalid", 32'(obs_d_rvalid), 32'h0);
        check("load_we",         32'(obs_mem_we),   32'h0);
        idle_inputs(); step();
        check("load_rvalid", 32'(obs_d_rvalid), 32'h1);
        check("load_rdata",  obs_d_rdata,       32'hDEAD_BEEF);

        // Continuous contention: D D D D I repeating.
        pat10 = '0;
        i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h44;
        for (int k = 0; k < 10; k++) begin
            step();
            pat10 = {pat10[8:0], obs_d_gnt};
        end
        check("streak_pattern", 32'(pat10), 32'(10'b11110_11110));
        idle_inputs(); step();

        // Flush in the grant cycle drops the fetch; data response still lands.
        d_req = 1'b1; d_addr = 32'h8; step();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h100; i_flush = 1'b1; step();
        check("flush_i_gnt",    32'(obs_i_gnt),    32'h1);
        check("flush_d_rvalid", 32'(obs_d_rvalid), 32'h1);
        check("flush_d_rdata",  obs_d_rdata,       32'h1000_0006);
        idle_inputs(); step();
        check("flush_no_rvalid", 32'(obs_i_rvalid), 32'h0);

        // Reset one cycle after a fetch grant discards the response at once.
        i_req = 1'b1; i_addr = 32'hC; step();
        rst_n = 1'b0; model_reset(); idle_inputs();
        #1;
        check("midrst_i_rvalid", 32'(i_rvalid), 32'h0);
        check("midrst_d_rvalid", 32'(d_rvalid), 32'h0);
        check("midrst_i_rdata",  i_rdata,       32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset clears a partial streak: afterwards contention restarts at D x4.
        i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_addr = 32'h34;
        repeat (3) step();
        rst_n = 1'b0; model_reset(); idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pat5 = '0;
        i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_addr = 32'h34;
        for (int k = 0; k < 5; k++) begin
            step();
            pat5 = {pat5[3:0], obs_d_gnt};
        end
        check("post_reset_pattern", 32'(pat5), 32'(5'b11110));
        idle_inputs(); step();

        // Constrained-random traffic; requests stay stable until granted.
        verbose = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!(i_req && !obs_i_gnt)) begin
                i_req  = ($urandom_range(2) != 0);
                i_addr = rand_addr();
            end
            if (!(d_req && !obs_d_gnt)) begin
                d_req   = ($urandom_range(2) != 0);
                d_we    = ($urandom_range(2) == 0);
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
            i_flush = ($urandom_range(7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
